// File: rtl/axil_uart_pkg.sv
// Shared constants and types for the UART AXI4-Lite register bank.
package axil_uart_pkg;

    // Register word indices (address bits [4:2])
    localparam logic [2:0] REG_RXDATA = 3'd0;
    localparam logic [2:0] REG_TXDATA = 3'd1;
    localparam logic [2:0] REG_BAUD   = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    // CTRL bit positions
    localparam int CTRL_TX_EN     = 8;
    localparam int CTRL_RX_EN     = 9;
    localparam int CTRL_RX_IRQ_EN = 10;
    localparam int CTRL_TX_IRQ_EN = 11;
    localparam int CTRL_WIDTH     = 12;

    // STATUS bit positions
    localparam int ST_RX_EMPTY     = 0;
    localparam int ST_RX_FULL      = 1;
    localparam int ST_TX_EMPTY     = 2;
    localparam int ST_TX_FULL      = 3;
    localparam int ST_RX_OVERRUN   = 4;
    localparam int ST_RX_COUNT_LSB = 16;

    // Reset values: 8 data bits, 1 stop, no parity, everything disabled
    localparam logic [CTRL_WIDTH-1:0] CTRL_RESET = 12'h008;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_RESP } r_state_t;

endpackage

// File: rtl/axil_uart_if.sv
// AXI4-Lite bus bundle between the interconnect and the UART register bank.
interface axil_uart_if #(
    parameter int P_ADDR_WIDTH = 16,
    parameter int P_DATA_WIDTH = 32
);
    logic [P_ADDR_WIDTH-1:0]   awaddr;
    logic                      awvalid;
    logic                      awready;
    logic [P_DATA_WIDTH-1:0]   wdata;
    logic [P_DATA_WIDTH/8-1:0] wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [P_ADDR_WIDTH-1:0]   araddr;
    logic                      arvalid;
    logic                      arready;
    logic [P_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_uart_fifo.sv
// First-word-fall-through FIFO; head is valid whenever not empty.
// A push on a full FIFO is accepted only if a pop frees a slot in the same cycle.
module axil_uart_fifo #(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [P_WIDTH-1:0]         push_data,
    input  logic                       pop,
    output logic [P_WIDTH-1:0]         head,
    output logic [$clog2(P_DEPTH):0]   count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(P_DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = 1;
    localparam logic [PW:0]   CNT_ONE   = 1;
    localparam logic [PW:0]   CNT_DEPTH = P_DEPTH;

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage array, no reset needed: contents are qualified by count
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/axil_uart_regs.sv
// AXI4-Lite register front end for the UART: TX/RX FIFOs, baud/frame config,
// status with sticky overrun, and a registered level interrupt.
module axil_uart_regs
    import axil_uart_pkg::*;
#(
    parameter int P_S_AXI_ADDR_WIDTH = 16,
    parameter int P_S_AXI_DATA_WIDTH = 32,
    parameter int P_TX_DEPTH         = 16,
    parameter int P_RX_DEPTH         = 16,
    parameter int P_CHAR_WIDTH       = 8,
    parameter int P_DEFAULT_DIV      = 868
) (
    input  logic                    clock,
    input  logic                    reset,
    axil_uart_if.slave              s_axi,
    output logic                    o_tx_valid,
    output logic [P_CHAR_WIDTH-1:0] o_tx_data,
    input  logic                    i_tx_ready,
    input  logic                    i_rx_valid,
    input  logic [P_CHAR_WIDTH-1:0] i_rx_data,
    output logic [23:0]             o_div_num,
    output logic [3:0]              o_data_bit,
    output logic [1:0]              o_stop_bit,
    output logic [1:0]              o_check_bit,
    output logic                    o_rts,
    output logic                    o_irq
);
    localparam int AW   = P_S_AXI_ADDR_WIDTH;
    localparam int TXCW = $clog2(P_TX_DEPTH) + 1;
    localparam int RXCW = $clog2(P_RX_DEPTH) + 1;
    localparam logic [RXCW-1:0] RTS_LEVEL = RXCW'(P_RX_DEPTH - 1);

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic                  ready_en;
    logic                  aw_held, w_held;
    logic [AW-1:0]         aw_addr_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;
    logic                  aw_fire, w_fire, ar_fire;
    logic [AW-1:0]         wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic                  wr_commit, wr_mapped, rd_mapped;
    logic [2:0]            wr_idx, rd_idx;
    logic [1:0]            bresp_q, rresp_q, wr_resp;
    logic [31:0]           rdata_q, rd_word;

    logic [23:0]           div_q;
    logic [CTRL_WIDTH-1:0] ctrl_q;
    logic                  rx_overrun, irq_q;

    logic                    tx_push_req, tx_push, tx_pop, tx_full, tx_empty;
    logic [TXCW-1:0]         tx_count;
    logic                    rx_push, rx_pop, rx_full, rx_empty, rx_ovr_set, rx_ovr_clr;
    logic [RXCW-1:0]         rx_count;
    logic [P_CHAR_WIDTH-1:0] rx_head;

    // Only offsets 0x00..0x10 exist; any higher address bit makes it unmapped
    function automatic logic addr_mapped(input logic [AW-1:0] a);
        return ((a >> 5) == '0) && (a[4:2] <= REG_STATUS);
    endfunction

    // ---------------- write channel ----------------
    assign s_axi.awready = ready_en & ~aw_held & (w_state == W_IDLE);
    assign s_axi.wready  = ready_en & ~w_held  & (w_state == W_IDLE);
    assign s_axi.bvalid  = (w_state == W_RESP);
    assign s_axi.bresp   = bresp_q;

    assign aw_fire   = s_axi.awvalid & s_axi.awready;
    assign w_fire    = s_axi.wvalid  & s_axi.wready;
    assign wr_addr   = aw_held ? aw_addr_q : s_axi.awaddr;
    assign wr_data   = w_held  ? w_data_q  : s_axi.wdata[31:0];
    assign wr_strb   = w_held  ? w_strb_q  : s_axi.wstrb[3:0];
    assign wr_commit = (w_state == W_IDLE) & (aw_held | aw_fire) & (w_held | w_fire);
    assign wr_mapped = addr_mapped(wr_addr);
    assign wr_idx    = wr_addr[4:2];

    assign tx_push_req = wr_commit & wr_mapped & (wr_idx == REG_TXDATA) & wr_strb[0];
    assign tx_push     = tx_push_req & ~tx_full;
    assign wr_resp     = (!wr_mapped || (tx_push_req && tx_full)) ? RESP_SLVERR : RESP_OKAY;

    // Write FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    // Write FSM next state: commit once both halves are present, hold response until bready
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (wr_commit)    w_next = W_RESP;
            W_RESP:  if (s_axi.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Ready enable plus independent AW/W capture and response latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_en  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            ready_en <= 1'b1;
            if (wr_commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= wr_resp;
            end else begin
                if (aw_fire) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= s_axi.awaddr;
                end
                if (w_fire) begin
                    w_held   <= 1'b1;
                    w_data_q <= s_axi.wdata[31:0];
                    w_strb_q <= s_axi.wstrb[3:0];
                end
            end
        end
    end

    // Configuration registers with per-lane byte strobes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q  <= 24'(P_DEFAULT_DIV);
            ctrl_q <= CTRL_RESET;
        end else if (wr_commit && wr_mapped) begin
            if (wr_idx == REG_BAUD) begin
                for (int i = 0; i < 3; i++) begin
                    if (wr_strb[i]) div_q[8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
            if (wr_idx == REG_CTRL) begin
                if (wr_strb[0]) ctrl_q[7:0]  <= wr_data[7:0];
                if (wr_strb[1]) ctrl_q[11:8] <= wr_data[11:8];
            end
        end
    end

    // ---------------- read channel ----------------
    assign s_axi.arready = ready_en & (r_state == R_IDLE);
    assign s_axi.rvalid  = (r_state == R_RESP);
    assign s_axi.rresp   = rresp_q;
    assign ar_fire       = s_axi.arvalid & s_axi.arready;
    assign rd_mapped     = addr_mapped(s_axi.araddr);
    assign rd_idx        = s_axi.araddr[4:2];
    assign rx_pop        = ar_fire & rd_mapped & (rd_idx == REG_RXDATA) & ~rx_empty;

    // Zero-extend the 32-bit register word onto wider buses
    always_comb begin
        s_axi.rdata       = '0;
        s_axi.rdata[31:0] = rdata_q;
    end

    // Read FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // Read FSM next state
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire)      r_next = R_RESP;
            R_RESP:  if (s_axi.rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read mux from pre-edge state, so a concurrent write is not visible yet
    always_comb begin
        rd_word = '0;
        if (rd_mapped) begin
            case (rd_idx)
                REG_RXDATA: begin
                    if (rx_empty) rd_word[31] = 1'b1;
                    else          rd_word[P_CHAR_WIDTH-1:0] = rx_head;
                end
                REG_BAUD:   rd_word[23:0] = div_q;
                REG_CTRL:   rd_word[CTRL_WIDTH-1:0] = ctrl_q;
                REG_STATUS: begin
                    rd_word[ST_RX_EMPTY]   = rx_empty;
                    rd_word[ST_RX_FULL]    = rx_full;
                    rd_word[ST_TX_EMPTY]   = tx_empty;
                    rd_word[ST_TX_FULL]    = tx_full;
                    rd_word[ST_RX_OVERRUN] = rx_overrun;
                    rd_word[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);
                end
                default: rd_word = '0;
            endcase
        end
    end

    // Registered read response
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_fire) begin
            rdata_q <= rd_word;
            rresp_q <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // ---------------- FIFOs, overrun, interrupt ----------------
    assign tx_pop     = o_tx_valid & i_tx_ready;
    assign o_tx_valid = ctrl_q[CTRL_TX_EN] & ~tx_empty;
    assign rx_push    = i_rx_valid & ctrl_q[CTRL_RX_EN] & (~rx_full | rx_pop);
    assign rx_ovr_set = i_rx_valid & ctrl_q[CTRL_RX_EN] & rx_full & ~rx_pop;
    assign rx_ovr_clr = wr_commit & wr_mapped & (wr_idx == REG_STATUS) & wr_strb[0]
                      & wr_data[ST_RX_OVERRUN];

    axil_uart_fifo #(.P_WIDTH(P_CHAR_WIDTH), .P_DEPTH(P_TX_DEPTH)) u_tx_fifo (
        .clock(clock), .reset(reset),
        .push(tx_push), .push_data(wr_data[P_CHAR_WIDTH-1:0]),
        .pop(tx_pop), .head(o_tx_data),
        .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    axil_uart_fifo #(.P_WIDTH(P_CHAR_WIDTH), .P_DEPTH(P_RX_DEPTH)) u_rx_fifo (
        .clock(clock), .reset(reset),
        .push(rx_push), .push_data(i_rx_data),
        .pop(rx_pop), .head(rx_head),
        .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    // Sticky overrun (a new overrun wins over a same-cycle clear) and registered irq
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_overrun <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rx_overrun <= rx_ovr_set | (rx_overrun & ~rx_ovr_clr);
            irq_q      <= (ctrl_q[CTRL_RX_IRQ_EN] & (~rx_empty | rx_overrun))
                        | (ctrl_q[CTRL_TX_IRQ_EN] & tx_empty);
        end
    end

    assign o_div_num   = div_q;
    assign o_data_bit  = ctrl_q[3:0];
    assign o_stop_bit  = ctrl_q[5:4];
    assign o_check_bit = ctrl_q[7:6];
    assign o_rts       = (rx_count >= RTS_LEVEL);
    assign o_irq       = irq_q;
endmodule

// File: tb/tb_axil_uart_regs.sv
// Scoreboard bench for axil_uart_regs: stimulus queues expected B/R/TX
// responses, independent monitors pop and compare on each handshake.
module tb_axil_uart_regs;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       i_tx_ready = 1'b0;
    logic       i_rx_valid = 1'b0;
    logic [7:0] i_rx_data  = '0;
    logic       o_tx_valid;
    logic [7:0] o_tx_data;
    logic [23:0] o_div_num;
    logic [3:0] o_data_bit;
    logic [1:0] o_stop_bit, o_check_bit;
    logic       o_rts, o_irq;

    int checks = 0;
    int errors = 0;

    logic [1:0]  exp_b  [$];
    logic [33:0] exp_r  [$];
    logic [7:0]  exp_tx [$];

    axil_uart_if #(.P_ADDR_WIDTH(16), .P_DATA_WIDTH(32)) axi ();

    axil_uart_regs dut (
        .clock(clock), .reset(reset), .s_axi(axi),
        .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
        .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
        .o_div_num(o_div_num), .o_data_bit(o_data_bit), .o_stop_bit(o_stop_bit),
        .o_check_bit(o_check_bit), .o_rts(o_rts), .o_irq(o_irq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // mode 0: AW and W together, 1: AW one cycle before W, 2: W before AW
    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] er, input int mode, input bit track);
        bit aw_done = 0;
        bit w_done  = 0;
        if (track) exp_b.push_back(er);
        @(negedge clock);
        axi.awaddr  = a;
        axi.wdata   = d;
        axi.wstrb   = s;
        axi.awvalid = (mode != 2);
        axi.wvalid  = (mode != 1);
        for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
            if (axi.awvalid && axi.awready) aw_done = 1;
            if (axi.wvalid && axi.wready)   w_done  = 1;
            @(negedge clock);
            if (aw_done) axi.awvalid = 0;
            if (w_done)  axi.wvalid  = 0;
            if (mode == 1 && aw_done && !w_done) axi.wvalid  = 1;
            if (mode == 2 && w_done && !aw_done) axi.awvalid = 1;
        end
        axi.awvalid = 0;
        axi.wvalid  = 0;
        chk("wr_handshake", {62'd0, aw_done, w_done}, 64'd3);
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] ed, input logic [1:0] er);
        bit done = 0;
        exp_r.push_back({er, ed});
        @(negedge clock);
        axi.araddr  = a;
        axi.arvalid = 1;
        for (int n = 0; n < 50 && !done; n++) begin
            if (axi.arready) done = 1;
            @(negedge clock);
        end
        axi.arvalid = 0;
        chk("rd_handshake", {63'd0, done}, 64'd1);
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        @(negedge clock);
        i_rx_valid = 1;
        i_rx_data  = d;
        @(negedge clock);
        i_rx_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Response / TX monitor: samples at negedge, handshake completes at the next posedge
    initial begin
        logic [1:0]  eb;
        logic [33:0] er;
        logic [7:0]  et;
        forever begin
            @(negedge clock);
            if (axi.bvalid && axi.bready) begin
                if (exp_b.size() == 0) chk("unexpected_b", 64'd1, 64'd0);
                else begin
                    eb = exp_b.pop_front();
                    chk("bresp", axi.bresp, eb);
                end
            end
            if (axi.rvalid && axi.rready) begin
                if (exp_r.size() == 0) chk("unexpected_r", 64'd1, 64'd0);
                else begin
                    er = exp_r.pop_front();
                    chk("rresp", axi.rresp, er[33:32]);
                    chk("rdata", axi.rdata, er[31:0]);
                end
            end
            if (o_tx_valid && i_tx_ready) begin
                if (exp_tx.size() == 0) chk("unexpected_tx", 64'd1, 64'd0);
                else begin
                    et = exp_tx.pop_front();
                    chk("tx_data", o_tx_data, et);
                end
            end
        end
    end

    initial begin
        axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0;
        axi.bready = 1;  axi.araddr = '0; axi.arvalid = 0; axi.rready = 1;

        // reset values
        idle(3);
        chk("rst_awready", axi.awready, 0);
        chk("rst_wready", axi.wready, 0);
        chk("rst_arready", axi.arready, 0);
        chk("rst_bvalid", axi.bvalid, 0);
        chk("rst_rvalid", axi.rvalid, 0);
        chk("rst_tx_valid", o_tx_valid, 0);
        chk("rst_irq", o_irq, 0);
        chk("rst_div", o_div_num, 868);
        chk("rst_data_bit", o_data_bit, 8);
        chk("rst_stop_check", {o_stop_bit, o_check_bit}, 0);
        chk("rst_rts", o_rts, 0);
        reset = 0;
        idle(1);
        chk("post_rst_ready", {axi.awready, axi.wready, axi.arready}, 3'b111);

        // BAUD write (AW before W), readback, byte-lane write
        wr(16'h0008, 32'h0000_01B2, 4'hF, OKAY, 1, 1);
        idle(1);
        chk("div_after_wr", o_div_num, 24'h0001B2);
        rd(16'h0008, 32'h0000_01B2, OKAY);
        wr(16'h0008, 32'h00AA_BBCC, 4'h2, OKAY, 0, 1);
        rd(16'h0008, 32'h0000_BBB2, OKAY);
        rd(16'h000C, 32'h0000_0008, OKAY);
        rd(16'h0004, 32'h0000_0000, OKAY);

        // TX fill with tx_en=0, overflow push rejected
        for (int i = 0; i < 16; i++) begin
            exp_tx.push_back(8'(8'h10 + i));
            wr(16'h0004, 32'h10 + i, 4'h1, OKAY, i % 3, 1);
        end
        wr(16'h0004, 32'h99, 4'h1, SLVERR, 0, 1);
        chk("tx_valid_disabled", o_tx_valid, 0);
        rd(16'h0010, 32'h0000_0009, OKAY);
        i_tx_ready = 1;
        wr(16'h000C, 32'h0000_0108, 4'h3, OKAY, 0, 1);
        idle(20);
        rd(16'h0010, 32'h0000_0005, OKAY);

        // RX overflow, RTS, overrun W1C, drain
        wr(16'h000C, 32'h0000_0208, 4'h3, OKAY, 0, 1);
        for (int i = 0; i < 17; i++) rx_pulse(8'(8'h40 + i));
        idle(1);
        chk("rts_full", o_rts, 1);
        chk("irq_disabled", o_irq, 0);
        rd(16'h0010, 32'h0010_0016, OKAY);
        wr(16'h0010, 32'h0000_0010, 4'h1, OKAY, 2, 1);
        rd(16'h0010, 32'h0010_0006, OKAY);
        rd(16'h0000, 32'h0000_0040, OKAY);
        rd(16'h0010, 32'h000F_0004, OKAY);
        idle(1);
        chk("rts_one_free", o_rts, 1);
        rd(16'h0000, 32'h0000_0041, OKAY);
        idle(1);
        chk("rts_two_free", o_rts, 0);
        for (int i = 2; i < 16; i++) rd(16'h0000, 32'h40 + i, OKAY);
        rd(16'h0000, 32'h8000_0000, OKAY);
        rd(16'h0010, 32'h0000_0005, OKAY);

        // interrupt sources
        wr(16'h000C, 32'h0000_0608, 4'h3, OKAY, 0, 1);
        idle(3);
        chk("irq_rx_idle", o_irq, 0);
        rx_pulse(8'h77);
        idle(3);
        chk("irq_rx_data", o_irq, 1);
        rd(16'h0000, 32'h0000_0077, OKAY);
        idle(3);
        chk("irq_rx_drained", o_irq, 0);
        wr(16'h000C, 32'h0000_0808, 4'h3, OKAY, 0, 1);
        idle(3);
        chk("irq_tx_empty", o_irq, 1);
        wr(16'h000C, 32'h0000_0008, 4'h3, OKAY, 0, 1);

        // unmapped accesses, no side effects
        rd(16'h0040, 32'h0000_0000, SLVERR);
        wr(16'h0014, 32'hFFFF_FFFF, 4'hF, SLVERR, 0, 1);
        wr(16'h8008, 32'h0000_0000, 4'hF, SLVERR, 0, 1);
        rd(16'h0008, 32'h0000_BBB2, OKAY);
        rd(16'h000C, 32'h0000_0008, OKAY);

        // reset while a write response is held
        axi.bready = 0;
        wr(16'h000C, 32'h0000_0308, 4'h3, OKAY, 0, 0);
        idle(2);
        chk("bvalid_held", axi.bvalid, 1);
        chk("ctrl_written", o_data_bit, 8);
        reset = 1;
        #1;
        chk("rst_mid_bvalid", axi.bvalid, 0);
        chk("rst_mid_div", o_div_num, 868);
        chk("rst_mid_awready", axi.awready, 0);
        idle(2);
        reset = 0;
        axi.bready = 1;
        rd(16'h000C, 32'h0000_0008, OKAY);
        wr(16'h0008, 32'h0000_0123, 4'hF, OKAY, 0, 1);
        rd(16'h0008, 32'h0000_0123, OKAY);

        idle(5);
        chk("b_queue_empty", exp_b.size(), 0);
        chk("r_queue_empty", exp_r.size(), 0);
        chk("tx_queue_empty", exp_tx.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
